// File: rtl/mem_port_arbiter.sv
// Arbitrates the single SPI memory controller between instruction fetch (IF) and load/store (LS).
// One cycle grant latency, done one cycle after mc_done; requests are held by their owners until done.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [23:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_write,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_nbytes,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        if_err,
    output logic        mc_start,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_nbytes,
    output logic        mc_write,
    output logic [31:0] mc_wdata,
    output logic        mc_is_data,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata,
    output logic        busy,
    output logic        grant_ls
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t      state;
    logic [31:0] wait_cnt;
    logic        size_ok;
    logic        pick_ls;
    logic        timed_out;

    assign size_ok   = (ls_nbytes == 3'd1) || (ls_nbytes == 3'd2) || (ls_nbytes == 3'd4);
    // On a tie the port that did not own the last access wins.
    assign pick_ls   = ls_req && (!if_req || !grant_ls);
    assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CYCLES - 1);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            if_done    <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= '0;
            ls_done    <= 1'b0;
            ls_err     <= 1'b0;
            ls_rdata   <= '0;
            mc_start   <= 1'b0;
            mc_addr    <= '0;
            mc_nbytes  <= '0;
            mc_write   <= 1'b0;
            mc_wdata   <= '0;
            mc_is_data <= 1'b0;
            grant_ls   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            if_err  <= 1'b0;
            ls_done <= 1'b0;
            ls_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req || ls_req) begin
                        grant_ls <= pick_ls;
                        wait_cnt <= '0;
                        if (pick_ls) begin
                            mc_addr    <= ls_addr;
                            mc_nbytes  <= ls_nbytes;
                            mc_write   <= ls_write;
                            mc_wdata   <= ls_wdata;
                            mc_is_data <= !ls_write;
                            if (size_ok) begin
                                mc_start <= 1'b1;
                                state    <= S_WAIT;
                            end else begin
                                ls_done  <= 1'b1;
                                ls_err   <= 1'b1;
                                ls_rdata <= '0;
                                state    <= S_RELEASE;
                            end
                        end else begin
                            mc_addr    <= {8'd0, if_addr};
                            mc_nbytes  <= 3'd4;
                            mc_write   <= 1'b0;
                            mc_wdata   <= '0;
                            mc_is_data <= 1'b0;
                            mc_start   <= 1'b1;
                            state      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A completion in the timeout cycle still counts as success.
                    if (mc_done) begin
                        mc_start <= 1'b0;
                        state    <= S_RELEASE;
                        if (grant_ls) begin
                            ls_rdata <= mc_rdata;
                            ls_done  <= 1'b1;
                        end else begin
                            if_rdata <= mc_rdata;
                            if_done  <= 1'b1;
                        end
                    end else if (timed_out) begin
                        mc_start <= 1'b0;
                        state    <= S_RELEASE;
                        if (grant_ls) begin
                            ls_rdata <= '0;
                            ls_done  <= 1'b1;
                            ls_err   <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_done  <= 1'b1;
                            if_err   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_RELEASE: begin
                    if (!mc_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
